// File: rtl/camera_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : camera_ctrl_fsm
//  Function : Top-level capture sequencer of the digital camera. Handles the
//             Init request, exposure (Start/Expose/Erase) and the two-row
//             readout strobe sequence (NRE_1, NRE_2, ADC), driven by the
//             Ovf5/Ovf4 pulses from the exposure timer/counter.
//  Options  : CAM_TIMEOUT_EN - adds an exposure watchdog that raises a
//             sticky Fault and aborts to IDLE after TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module camera_ctrl_fsm #(
    parameter int unsigned STEP_CYCLES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_i,
    input  logic ovf5_i,
    input  logic ovf4_i,
    output logic start_o,
    output logic erase_o,
    output logic expose_o,
    output logic nre_1_o,
    output logic nre_2_o,
    output logic adc_o,
    output logic busy_o,
    output logic fault_o
);

    // Last count value of a readout step (each step lasts STEP_CYCLES cycles).
    localparam logic [3:0] c_STEP_LAST = 4'(STEP_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_EXPOSE   = 4'd1,
        ST_R1       = 4'd2,
        ST_R2       = 4'd3,
        ST_R3       = 4'd4,
        ST_R4       = 4'd5,
        ST_R5       = 4'd6,
        ST_R6       = 4'd7,
        ST_R7       = 4'd8,
        ST_R8       = 4'd9,
        ST_WAIT_END = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic       done_q, done_d;

    // Registered Moore outputs: next values are decoded from the next state.
    logic start_q,  start_d;
    logic erase_q,  erase_d;
    logic expose_q, expose_d;
    logic nre_1_q,  nre_1_d;
    logic nre_2_q,  nre_2_d;
    logic adc_q,    adc_d;
    logic busy_q,   busy_d;

    logic w_step_done;

`ifdef CAM_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_q, to_d;
    logic       fault_q, fault_d;
`endif

    assign w_step_done = (step_q == c_STEP_LAST);

    // State, step counter, done flag and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            step_q   <= 4'd0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            erase_q  <= 1'b1;
            expose_q <= 1'b0;
            nre_1_q  <= 1'b1;
            nre_2_q  <= 1'b1;
            adc_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            done_q   <= done_d;
            start_q  <= start_d;
            erase_q  <= erase_d;
            expose_q <= expose_d;
            nre_1_q  <= nre_1_d;
            nre_2_q  <= nre_2_d;
            adc_q    <= adc_d;
            busy_q   <= busy_d;
        end
    end

`ifdef CAM_TIMEOUT_EN
    // Exposure watchdog counter and sticky fault flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_q    <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            to_q    <= to_d;
            fault_q <= fault_d;
        end
    end
`endif

    // Next-state logic, readout step timing and Ovf4 latching.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = done_q;
`ifdef CAM_TIMEOUT_EN
        to_d    = to_q;
        fault_d = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (init_i) begin
                    state_d = ST_EXPOSE;
                    step_d  = 4'd0;
`ifdef CAM_TIMEOUT_EN
                    to_d    = 8'd0;
`endif
                end
            end
            ST_EXPOSE: begin
                // Ovf5 wins over a watchdog expiry on the same edge.
                if (ovf5_i) begin
                    state_d = ST_R1;
                    step_d  = 4'd0;
                end
`ifdef CAM_TIMEOUT_EN
                else if (to_q == c_TO_LAST) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end else begin
                    to_d = to_q + 8'd1;
                end
`endif
            end
            ST_R1, ST_R2, ST_R3, ST_R4, ST_R5, ST_R6, ST_R7: begin
                if (w_step_done) begin
                    state_d = state_t'(state_q + 4'd1);
                    step_d  = 4'd0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_R8: begin
                // An Ovf4 arriving on the final edge counts as already seen,
                // otherwise WAIT_END would wait for a pulse that has passed.
                if (w_step_done) begin
                    step_d  = 4'd0;
                    state_d = (done_q || ovf4_i) ? ST_IDLE : ST_WAIT_END;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_WAIT_END: begin
                if (ovf4_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 4'd0;
            end
        endcase

        // Done flag: cleared on every IDLE entry, set by Ovf4 outside IDLE.
        if (state_d == ST_IDLE) begin
            done_d = 1'b0;
        end else if (ovf4_i && (state_q != ST_IDLE)) begin
            done_d = 1'b1;
        end
    end

    // Output decode of the state being entered.
    always_comb begin
        start_d  = 1'b1;
        erase_d  = 1'b0;
        expose_d = 1'b0;
        nre_1_d  = 1'b1;
        nre_2_d  = 1'b1;
        adc_d    = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE: begin
                start_d = 1'b0;
                erase_d = 1'b1;
            end
            ST_EXPOSE: expose_d = 1'b1;
            ST_R1:     nre_1_d  = 1'b0;
            ST_R2: begin
                nre_1_d = 1'b0;
                adc_d   = 1'b1;
            end
            ST_R3:     nre_1_d  = 1'b0;
            ST_R5:     nre_2_d  = 1'b0;
            ST_R6: begin
                nre_2_d = 1'b0;
                adc_d   = 1'b1;
            end
            ST_R7:     nre_2_d  = 1'b0;
            default: begin
                // R4, R8 and WAIT_END: Start held, all strobes inactive.
            end
        endcase
    end

    assign start_o  = start_q;
    assign erase_o  = erase_q;
    assign expose_o = expose_q;
    assign nre_1_o  = nre_1_q;
    assign nre_2_o  = nre_2_q;
    assign adc_o    = adc_q;
    assign busy_o   = busy_q;

`ifdef CAM_TIMEOUT_EN
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_camera_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_ctrl_fsm
//  Function : Directed self-checking bench for camera_ctrl_fsm. Expected
//             output vectors are hand-derived per cycle.
//             Vector layout: {Start, Erase, Expose, NRE_1, NRE_2, ADC, Busy}
//  Revision : 1.0 - initial release
// ============================================================================
module tb_camera_ctrl_fsm;

    localparam logic [6:0] c_IDLE = 7'b0_1_0_1_1_0_0;
    localparam logic [6:0] c_EXP  = 7'b1_0_1_1_1_0_1;
    localparam logic [6:0] c_R1   = 7'b1_0_0_0_1_0_1;
    localparam logic [6:0] c_R2   = 7'b1_0_0_0_1_1_1;
    localparam logic [6:0] c_R4   = 7'b1_0_0_1_1_0_1;
    localparam logic [6:0] c_R5   = 7'b1_0_0_1_0_0_1;
    localparam logic [6:0] c_R6   = 7'b1_0_0_1_0_1_1;
    localparam logic [6:0] c_WAIT = 7'b1_0_0_1_1_0_1;

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    logic r_init = 1'b0;
    logic r_ovf5 = 1'b0;
    logic r_ovf4 = 1'b0;
    logic w_start, w_erase, w_expose, w_nre_1, w_nre_2, w_adc, w_busy, w_fault;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   adc_cnt  = 0;
    logic r_fault_exp = 1'b0;

    camera_ctrl_fsm #(
        .STEP_CYCLES    (1),
        .TIMEOUT_CYCLES (64)
    ) u_dut (
        .clk_i    (r_clk),
        .rst_i    (r_rst),
        .init_i   (r_init),
        .ovf5_i   (r_ovf5),
        .ovf4_i   (r_ovf4),
        .start_o  (w_start),
        .erase_o  (w_erase),
        .expose_o (w_expose),
        .nre_1_o  (w_nre_1),
        .nre_2_o  (w_nre_2),
        .adc_o    (w_adc),
        .busy_o   (w_busy),
        .fault_o  (w_fault)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {w_fault, w_start, w_erase, w_expose, w_nre_1, w_nre_2, w_adc, w_busy};
    endfunction

    // Readout state k (1..8) expected vector.
    function automatic logic [6:0] rd_exp(input int k);
        case (k)
            1, 3:    return c_R1;
            2:       return c_R2;
            5, 7:    return c_R5;
            6:       return c_R6;
            default: return c_R4;
        endcase
    endfunction

    // Drive inputs, take one rising edge, then check 1 time unit later.
    task automatic cyc(input logic i_init, input logic i_o5, input logic i_o4,
                       input logic [6:0] exp, input string tag);
        r_init = i_init;
        r_ovf5 = i_o5;
        r_ovf4 = i_o4;
        @(posedge r_clk);
        #1;
        if (w_adc) adc_cnt++;
        check_eq(tag, {24'd0, outs()}, {24'd0, r_fault_exp, exp});
    endtask

    initial begin
        // ---------------- reset behaviour ----------------
        repeat (3) @(posedge r_clk);
        #1;
        check_eq("reset_hold", {24'd0, outs()}, {24'd0, 1'b0, c_IDLE});
        r_rst = 1'b0;
        cyc(0, 0, 0, c_IDLE, "post_reset");
        cyc(0, 1, 0, c_IDLE, "idle_ovf5_ignored");
        cyc(0, 0, 1, c_IDLE, "idle_ovf4_ignored");
        cyc(0, 1, 1, c_IDLE, "idle_both_ignored");
        cyc(0, 0, 0, c_IDLE, "idle_stable");

        // ---------------- normal capture with WAIT_END ----------------
        cyc(1, 0, 0, c_EXP, "cap_expose_entry");
        for (int i = 1; i < 10; i++) cyc(0, 0, 0, c_EXP, "cap_expose_hold");
        cyc(0, 1, 0, c_R1, "cap_r1");
        for (int k = 2; k <= 8; k++) cyc(0, 0, 0, rd_exp(k), "cap_readout");
        for (int i = 18; i < 40; i++) cyc(0, 0, 0, c_WAIT, "cap_wait_end");
        cyc(0, 0, 1, c_IDLE, "cap_idle_on_ovf4");
        cyc(0, 0, 0, c_IDLE, "cap_idle_stay");

        // ---------------- Ovf4 during R3: no WAIT_END ----------------
        cyc(1, 0, 0, c_EXP, "r3_expose");
        cyc(0, 1, 0, c_R1, "r3_r1");
        cyc(0, 0, 0, c_R2, "r3_r2");
        cyc(0, 0, 0, c_R1, "r3_r3");
        cyc(0, 0, 1, c_R4, "r3_r4_ovf4");
        for (int k = 5; k <= 8; k++) cyc(0, 0, 0, rd_exp(k), "r3_readout");
        cyc(0, 0, 0, c_IDLE, "r3_direct_idle");

        // ---------------- asynchronous reset during R6 ----------------
        cyc(1, 0, 0, c_EXP, "ar_expose");
        cyc(0, 1, 1, c_R1, "ar_r1_both");
        for (int k = 2; k <= 6; k++) cyc(0, 0, 0, rd_exp(k), "ar_readout");
        r_rst = 1'b1;
        #2;
        check_eq("ar_immediate", {24'd0, outs()}, {24'd0, 1'b0, c_IDLE});
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        cyc(0, 0, 0, c_IDLE, "ar_resume_idle");
        // Done flag must be cleared by reset: this capture has to wait for Ovf4.
        cyc(1, 0, 0, c_EXP, "ar2_expose");
        cyc(0, 0, 0, c_EXP, "ar2_expose_hold");
        cyc(0, 1, 0, c_R1, "ar2_r1");
        for (int k = 2; k <= 8; k++) cyc(0, 0, 0, rd_exp(k), "ar2_readout");
        cyc(0, 0, 0, c_WAIT, "ar2_wait_end");
        cyc(0, 0, 0, c_WAIT, "ar2_wait_end");
        cyc(0, 0, 1, c_IDLE, "ar2_idle");

        // ---------------- Init held high ----------------
        adc_cnt = 0;
        cyc(1, 0, 0, c_EXP, "ih_expose");
        cyc(1, 1, 0, c_R1, "ih_r1");
        for (int k = 2; k <= 6; k++) cyc(1, 0, 0, rd_exp(k), "ih_readout");
        cyc(1, 0, 1, c_R5, "ih_r7_ovf4");
        cyc(1, 0, 0, c_R4, "ih_r8");
        cyc(1, 0, 0, c_IDLE, "ih_idle_once");
        cyc(1, 0, 0, c_EXP, "ih_reexpose");
        cyc(0, 1, 0, c_R1, "ih2_r1");
        cyc(0, 0, 0, c_R2, "ih2_r2");
        cyc(0, 0, 0, c_R1, "ih2_r3");
        cyc(0, 0, 1, c_R4, "ih2_r4_ovf4");
        for (int k = 5; k <= 8; k++) cyc(0, 0, 0, rd_exp(k), "ih2_readout");
        cyc(0, 0, 0, c_IDLE, "ih2_idle");
        check_eq("ih_adc_pulses", adc_cnt, 32'd4);

`ifdef CAM_TIMEOUT_EN
        // ---------------- exposure watchdog ----------------
        adc_cnt = 0;
        cyc(1, 0, 0, c_EXP, "to_expose");
        for (int i = 1; i < 64; i++) cyc(0, 0, 0, c_EXP, "to_expose_hold");
        r_fault_exp = 1'b1;
        cyc(0, 0, 0, c_IDLE, "to_fault_idle");
        cyc(0, 0, 0, c_IDLE, "to_idle_stay");
        check_eq("to_no_adc", adc_cnt, 32'd0);
        cyc(1, 0, 0, c_EXP, "to_recapture");
        cyc(0, 1, 1, c_R1, "to_r1");
        for (int k = 2; k <= 8; k++) cyc(0, 0, 0, rd_exp(k), "to_readout");
        cyc(0, 0, 0, c_IDLE, "to_final_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
